// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
// The controller is the master; the multiply/divide unit is the slave.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rslt;

   modport master (
      output start, funct3, a, b,
      input  busy, done, rslt
   );

   modport slave (
      input  start, funct3, a, b,
      output busy, done, rslt
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per clock, with fast path for special divides.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               fast_q, fast_d;
   logic [WIDTH-1:0]   rslt_q, rslt_d;

   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               b_zero, ovf;
   logic [WIDTH-1:0]   fast_res;
   logic [WIDTH:0]     sum, tmp, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   dres;
   logic [WIDTH-1:0]   fin;

   // Operand classification at request time
   always_comb begin
      sgn_a  = bus.a[WIDTH-1] & ((bus.funct3 == 3'b001) |
                                 (bus.funct3 == 3'b010) |
                                 (bus.funct3 == 3'b100) |
                                 (bus.funct3 == 3'b110));
      sgn_b  = bus.b[WIDTH-1] & ((bus.funct3 == 3'b001) |
                                 (bus.funct3 == 3'b100) |
                                 (bus.funct3 == 3'b110));
      abs_a  = sgn_a ? -bus.a : bus.a;
      abs_b  = sgn_b ? -bus.b : bus.b;
      b_zero = (bus.b == '0);
      ovf    = !bus.funct3[0] &&
               (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (bus.b == '1);
      fast_res = '0;
      if (b_zero)
         fast_res = bus.funct3[1] ? bus.a : '1;
      else if (ovf)
         fast_res = bus.funct3[1] ? '0 : bus.a;
   end

   // One iteration of each datapath
   always_comb begin
      sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
             (acc_q[0] ? {1'b0, opnd_q} : '0);
      tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff = tmp - {1'b0, opnd_q};
   end

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      dres = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      if (neg_q)
         dres = -dres;
      if (fast_q)
         fin = acc_q[WIDTH-1:0];
      else if (op_q[2])
         fin = dres;
      else if (op_q[1:0] == 2'b00)
         fin = prod[WIDTH-1:0];
      else
         fin = prod[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      fast_d  = fast_q;
      rslt_d  = rslt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d   = bus.funct3;
               cnt_d  = CW'(WIDTH-1);
               neg_d  = (bus.funct3[2:1] == 2'b11) ? sgn_a : (sgn_a ^ sgn_b);
               fast_d = 1'b0;
               if (bus.funct3[2] && (b_zero || ovf)) begin
                  fast_d  = 1'b1;
                  acc_d   = {{WIDTH{1'b0}}, fast_res};
                  state_d = FINISH;
               end else if (bus.funct3[2]) begin
                  acc_d   = {{WIDTH{1'b0}}, abs_a};
                  opnd_d  = abs_b;
                  state_d = CALC;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, abs_b};
                  opnd_d  = abs_a;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (op_q[2]) begin
               acc_d = {diff[WIDTH] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0],
                        acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
               acc_d = {sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0)
               state_d = FINISH;
         end
         FINISH: begin
            rslt_d  = fin;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         fast_q  <= 1'b0;
         rslt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         fast_q  <= fast_d;
         rslt_q  <= rslt_d;
      end
   end

   // Result is visible in the done cycle itself, then held in rslt_q
   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == FINISH);
   assign bus.rslt = (state_q == FINISH) ? fin : rslt_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected results,
// a negedge monitor checks every done pulse for value and cycle.
module tb_muldiv_unit;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] res;
      int           at;
      string        nm;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   muldiv_unit_if #(.WIDTH(W)) mif ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && mif.done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done at cycle %0d want none", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.nm, "_rslt"}, mif.rslt, e.res);
            chk({e.nm, "_cycle"}, W'(cyc), W'(e.at));
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res,
                        input bit fast, input string nm);
      exp_t e;
      @(negedge clk);
      mif.funct3 = f;
      mif.a      = a;
      mif.b      = b;
      mif.start  = 1'b1;
      e.res = res;
      e.at  = cyc + 1 + (fast ? 0 : W);
      e.nm  = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      mif.start = 1'b0;
      chk({nm, "_busy"}, W'(mif.busy), W'(1));
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((mif.busy || sb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got busy after %0d cycles want idle", nm, n);
      end
   endtask

   initial begin
      exp_t e;
      int   n;
      mif.start  = 1'b0;
      mif.funct3 = 3'b000;
      mif.a      = '0;
      mif.b      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", W'(mif.busy), W'(0));
      chk("rst_done", W'(mif.done), W'(0));
      chk("rst_rslt", mif.rslt, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      issue(3'b000, 32'd7, 32'd6, 32'd42, 0, "mul");
      wait_idle("mul");
      issue(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 0, "mul_neg");
      wait_idle("mul_neg");
      issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh");
      wait_idle("mulh");
      issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
      wait_idle("mulhu");
      issue(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, "mulhsu");
      wait_idle("mulhsu");
      issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div");
      wait_idle("div");
      issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem");
      wait_idle("rem");
      issue(3'b101, 32'd100, 32'd7, 32'd14, 0, "divu");
      wait_idle("divu");
      repeat (3) @(negedge clk);
      chk("hold_rslt", mif.rslt, 32'd14);
      issue(3'b111, 32'd100, 32'd7, 32'd2, 0, "remu");
      wait_idle("remu");

      issue(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
      wait_idle("divu_by0");
      issue(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
      wait_idle("remu_by0");
      issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      wait_idle("div_ovf");
      issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");
      wait_idle("rem_ovf");

      issue(3'b000, 32'd7, 32'd6, 32'd42, 0, "mul_ignore");
      @(negedge clk);
      mif.funct3 = 3'b101;
      mif.a      = 32'd1;
      mif.b      = 32'd0;
      mif.start  = 1'b1;
      repeat (3) @(negedge clk);
      mif.start  = 1'b0;
      mif.a      = 32'd123;
      mif.b      = 32'd456;
      n = 0;
      while (!mif.done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL mul_ignore_timeout: got no done want done");
      end
      mif.funct3 = 3'b101;
      mif.a      = 32'd100;
      mif.b      = 32'd7;
      mif.start  = 1'b1;
      e.res = 32'd14;
      e.at  = cyc + 2 + W;
      e.nm  = "b2b";
      sb.push_back(e);
      @(posedge clk);
      @(posedge clk);
      #1;
      mif.start = 1'b0;
      chk("b2b_busy", W'(mif.busy), W'(1));
      wait_idle("b2b");

      issue(3'b101, 32'd1000, 32'd3, 32'd333, 0, "abort");
      repeat (9) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      chk("abort_busy", W'(mif.busy), W'(0));
      chk("abort_done", W'(mif.done), W'(0));
      chk("abort_rslt", mif.rslt, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      issue(3'b101, 32'd1000, 32'd3, 32'd333, 0, "after_rst");
      wait_idle("after_rst");

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
